// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared mode and function-select encodings for the pipelined ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    typedef enum logic [3:0] {
        SEL_0 = 4'h0, SEL_1 = 4'h1, SEL_2 = 4'h2, SEL_3 = 4'h3,
        SEL_4 = 4'h4, SEL_5 = 4'h5, SEL_6 = 4'h6, SEL_7 = 4'h7,
        SEL_8 = 4'h8, SEL_9 = 4'h9, SEL_A = 4'hA, SEL_B = 4'hB,
        SEL_C = 4'hC, SEL_D = 4'hD, SEL_E = 4'hE, SEL_F = 4'hF
    } alu_sel_e;

    // Common aliases: arithmetic A+B+cin, A+~B+cin (A-B with cin=1), logic A^B
    localparam alu_sel_e SEL_ADD = SEL_9;
    localparam alu_sel_e SEL_SUB = SEL_6;
    localparam alu_sel_e SEL_XOR = SEL_6;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module : alu_core
// Brief  : Combinational 74181-style function unit with true carry/overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    input  logic             mode,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] sum;
    logic             sum_carry;
    logic [WIDTH-1:0] logic_res;

    always_comb begin
        x = '0;
        y = '0;
        case (sel)
            SEL_0: begin x = a;        y = '0;       end
            SEL_1: begin x = a | b;    y = '0;       end
            SEL_2: begin x = a | ~b;   y = '0;       end
            SEL_3: begin x = '0;       y = '1;       end
            SEL_4: begin x = a;        y = a & ~b;   end
            SEL_5: begin x = a | b;    y = a & ~b;   end
            SEL_6: begin x = a;        y = ~b;       end
            SEL_7: begin x = a & ~b;   y = '1;       end
            SEL_8: begin x = a;        y = a & b;    end
            SEL_9: begin x = a;        y = b;        end
            SEL_A: begin x = a | ~b;   y = a & b;    end
            SEL_B: begin x = a & b;    y = '1;       end
            SEL_C: begin x = a;        y = a;        end
            SEL_D: begin x = a | b;    y = a;        end
            SEL_E: begin x = a | ~b;   y = a;        end
            default: begin x = a;      y = '1;       end
        endcase
        {sum_carry, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        logic_res = '0;
        case (sel)
            SEL_0: logic_res = ~a;
            SEL_1: logic_res = ~(a | b);
            SEL_2: logic_res = ~a & b;
            SEL_3: logic_res = '0;
            SEL_4: logic_res = ~(a & b);
            SEL_5: logic_res = ~b;
            SEL_6: logic_res = a ^ b;
            SEL_7: logic_res = a & ~b;
            SEL_8: logic_res = ~a | b;
            SEL_9: logic_res = ~(a ^ b);
            SEL_A: logic_res = b;
            SEL_B: logic_res = a & b;
            SEL_C: logic_res = '1;
            SEL_D: logic_res = a | ~b;
            SEL_E: logic_res = a | b;
            default: logic_res = a;
        endcase
    end

    always_comb begin
        result   = (mode == MODE_LOGIC) ? logic_res : sum;
        carry    = (mode == MODE_ARITH) & sum_carry;
        // Signed overflow: like-signed addends producing a result of the other sign
        overflow = (mode == MODE_ARITH) & (x[WIDTH-1] == y[WIDTH-1])
                   & (sum[WIDTH-1] != x[WIDTH-1]);
    end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module : alu_pipe
// Brief  : Two-stage valid/ready pipelined ALU with chained carry flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_pipe
    import alu_pkg::*;
#(
    parameter int   WIDTH      = 16,
    parameter logic CFLAG_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       select,
    input  logic             mode,
    input  logic             carry_in,
    input  logic             use_cflag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             compare,
    output logic             cflag
);

    logic             en;
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] a1_q, a1_d;
    logic [WIDTH-1:0] b1_q, b1_d;
    logic [3:0]       sel1_q, sel1_d;
    logic             mode1_q, mode1_d;
    logic             cin1_q, cin1_d;
    logic             ucf1_q, ucf1_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             cmp_q, cmp_d;
    logic             cflag_q, cflag_d;

    logic [WIDTH-1:0] core_res;
    logic             core_carry;
    logic             core_ovf;

    assign en       = !out_valid_q | out_ready;
    assign in_ready = en;

    // Carry-in is resolved at compute time so a chained op sees the flag its predecessor just wrote
    alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (a1_q),
        .b        (b1_q),
        .sel      (sel1_q),
        .mode     (mode1_q),
        .cin      (ucf1_q ? cflag_q : cin1_q),
        .result   (core_res),
        .carry    (core_carry),
        .overflow (core_ovf)
    );

    always_comb begin
        v1_d        = v1_q;
        a1_d        = a1_q;
        b1_d        = b1_q;
        sel1_d      = sel1_q;
        mode1_d     = mode1_q;
        cin1_d      = cin1_q;
        ucf1_d      = ucf1_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        co_d        = co_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        cmp_d       = cmp_q;
        cflag_d     = cflag_q;
        if (en) begin
            v1_d        = in_valid;
            a1_d        = in_a;
            b1_d        = in_b;
            sel1_d      = select;
            mode1_d     = mode;
            cin1_d      = carry_in;
            ucf1_d      = use_cflag;
            out_valid_d = v1_q;
            if (v1_q) begin
                res_d  = core_res;
                co_d   = core_carry;
                ovf_d  = core_ovf;
                zero_d = (core_res == '0);
                neg_d  = core_res[WIDTH-1];
                cmp_d  = (a1_q == b1_q);
                if (mode1_q == MODE_ARITH) begin
                    cflag_d = core_carry;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q        <= 1'b0;
            a1_q        <= '0;
            b1_q        <= '0;
            sel1_q      <= '0;
            mode1_q     <= 1'b0;
            cin1_q      <= 1'b0;
            ucf1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            cmp_q       <= 1'b0;
            cflag_q     <= CFLAG_INIT;
        end else begin
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            sel1_q      <= sel1_d;
            mode1_q     <= mode1_d;
            cin1_q      <= cin1_d;
            ucf1_q      <= ucf1_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            co_q        <= co_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            cmp_q       <= cmp_d;
            cflag_q     <= cflag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out   = res_q;
    assign carry_out = co_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign compare   = cmp_q;
    assign cflag     = cflag_q;

endmodule

`default_nettype wire
